// File: rtl/sprite_pkg.sv
// Shared types and sprite-sheet geometry for the sprite animation controller.
// Contents:
//   anim_state_t : motion FSM state. The encoding doubles as the sheet row.
//   SPRITE_W/H   : sprite frame size in pixels.
//   SHEET_COLS   : animation columns per sheet row.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK_R = 2'd1,
        WALK_L = 2'd2,
        JUMP   = 2'd3
    } anim_state_t;

    localparam int SPRITE_W   = 32;
    localparam int SPRITE_H   = 52;
    localparam int SHEET_COLS = 4;

endpackage

// File: rtl/sprite_anim_ctrl_frame_tick_detect.sv
// Turns the VGA vertical sync into a one-cycle animation tick.
// Ports:
//   Clk       in  system clock
//   Reset_n   in  synchronous active-low reset
//   frame_clk in  vertical sync, synchronous to Clk
//   freeze    in  suppresses the tick while high (a dropped tick is not queued)
//   tick      out high for the single cycle where frame_clk has just risen
module frame_tick_detect (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    input  logic freeze,
    output logic tick
);

    logic r_frame_clk_q;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_frame_clk_q <= 1'b0;
        end else begin
            r_frame_clk_q <= frame_clk;
        end
    end

    assign tick = frame_clk & ~r_frame_clk_q & ~freeze;

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Sprite sequencer sitting between the keycode decoder and color_mapper.
// Advances the motion FSM, the animation column and the sprite position
// once per video frame.
// Ports:
//   Clk, Reset_n          clock and synchronous active-low reset
//   frame_clk             vertical sync; each rising edge is one tick
//   freeze                while high, ticks are ignored
//   move_left/move_right  walk requests, sampled on the tick
//   jump                  jump request, sampled on the tick
//   sel                   {row, col} frame index into the 4x4 sheet
//   shape_x, shape_y      sprite top-left position
//   state_o               current motion state (equals the sheet row)
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int START_X   = 304,
    parameter int GROUND_Y  = 400,
    parameter int SCREEN_W  = 640,
    parameter int X_STEP    = 2,
    parameter int JUMP_DY   = 4,
    parameter int JUMP_LOG2 = 4,
    parameter int STEP_DIV  = 6
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       freeze,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       jump,
    output logic [3:0] sel,
    output logic [9:0] shape_x,
    output logic [9:0] shape_y,
    output logic [1:0] state_o
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [JUMP_LOG2-1:0] JUMP_LAST = '1;
    localparam logic [JUMP_LOG2-1:0] JUMP_HALF = JUMP_LOG2'(1 << (JUMP_LOG2 - 1));
    localparam logic [10:0]          X_MAX     = 11'(SCREEN_W - SPRITE_W);
    localparam logic [9:0]           X_STEP_W  = 10'(X_STEP);
    localparam logic [9:0]           DY_W      = 10'(JUMP_DY);

    anim_state_t          r_state;
    anim_state_t          w_next_state;
    logic [1:0]           r_col;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [JUMP_LOG2-1:0] r_jump_cnt;
    logic [JUMP_LOG2-1:0] w_jcnt_cur;
    logic [JUMP_LOG2-1:0] w_jcnt_inc;
    logic [9:0]           r_shape_x;
    logic [9:0]           r_shape_y;
    logic [10:0]          w_nx;
    logic                 w_tick;
    logic                 w_jump_path;
    logic                 w_jump_exit;

    frame_tick_detect u_tick (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .freeze    (freeze),
        .tick      (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        w_jump_exit  = 1'b0;
        if (r_state == JUMP) begin
            if (r_jump_cnt == JUMP_LAST) begin
                w_next_state = IDLE;
                w_jump_exit  = 1'b1;
            end
        end else if (jump) begin
            w_next_state = JUMP;
        end else if (move_right ^ move_left) begin
            w_next_state = move_right ? WALK_R : WALK_L;
        end else begin
            w_next_state = IDLE;
        end

        // The exit tick still runs the jump update so y lands on GROUND_Y,
        // and the entry tick starts counting from zero.
        w_jump_path = (r_state == JUMP) || (w_next_state == JUMP);
        w_jcnt_cur  = (r_state == JUMP) ? r_jump_cnt : '0;
        w_jcnt_inc  = w_jcnt_cur + JUMP_LOG2'(1);

        w_nx = {1'b0, r_shape_x} + 11'(X_STEP);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_div_cnt  <= '0;
            r_jump_cnt <= '0;
            r_shape_x  <= 10'(START_X);
            r_shape_y  <= 10'(GROUND_Y);
        end else if (w_tick) begin
            r_state <= w_next_state;
            if (w_jump_path) begin
                r_jump_cnt <= w_jcnt_inc;
                r_div_cnt  <= '0;
                // Post-increment count wraps to zero on exit; hold the last column.
                r_col      <= w_jump_exit ? 2'd3 : w_jcnt_inc[JUMP_LOG2-1 -: 2];
                if (w_jcnt_cur < JUMP_HALF) begin
                    r_shape_y <= r_shape_y - DY_W;
                end else begin
                    r_shape_y <= r_shape_y + DY_W;
                end
            end else begin
                if (w_next_state != r_state) begin
                    r_col     <= '0;
                    r_div_cnt <= '0;
                end else if (r_div_cnt == DIV_LAST) begin
                    r_col     <= r_col + 2'd1;
                    r_div_cnt <= '0;
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end

                case (w_next_state)
                    WALK_R: begin
                        if (w_nx > X_MAX) begin
                            r_shape_x <= X_MAX[9:0];
                        end else begin
                            r_shape_x <= w_nx[9:0];
                        end
                    end
                    WALK_L: begin
                        if (r_shape_x < X_STEP_W) begin
                            r_shape_x <= '0;
                        end else begin
                            r_shape_x <= r_shape_x - X_STEP_W;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sel     = {r_state, r_col};
    assign shape_x = r_shape_x;
    assign shape_y = r_shape_y;
    assign state_o = r_state;

endmodule
